// File: rtl/bs_mac_if.sv
// Result stream of the bit-serial MAC array: signed result, neuron index, valid/ready handshake.
interface bs_mac_if #(
    parameter int unsigned ACC_W = 34,
    parameter int unsigned IDX_W = 3
);
    logic [ACC_W-1:0] out_data;
    logic [IDX_W-1:0] out_idx;
    logic             out_valid;
    logic             out_ready;

    modport master (output out_data, out_idx, out_valid, input out_ready);
    modport slave  (input out_data, out_idx, out_valid, output out_ready);
endinterface

// File: rtl/bs_mac_array.sv
// Bit-serial MAC array: N_LANES neurons per group, one input bit per cycle (LSB first, MSB
// weighted negative), results drained one lane at a time over a valid/ready stream.
module bs_mac_array #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned N_IN     = 4,
    parameter int unsigned N_HIDDEN = 8,
    parameter int unsigned N_LAYERS = 3,
    parameter int unsigned N_LANES  = 2,
    localparam int unsigned ACC_W = 2 * DATA_W + $clog2(N_IN > 2 ? N_IN : 2),
    localparam int unsigned PW    = $clog2(DATA_W + 1),
    localparam int unsigned G     = N_HIDDEN / N_LANES,
    localparam int unsigned LIW   = N_LAYERS > 1 ? $clog2(N_LAYERS) : 1,
    localparam int unsigned AW    = (N_LAYERS * G * N_IN) > 1 ? $clog2(N_LAYERS * G * N_IN) : 1,
    localparam int unsigned IDX_W = N_HIDDEN > 1 ? $clog2(N_HIDDEN) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [LIW-1:0]              layer_idx,
    input  logic                        start_compute,
    input  logic [PW-1:0]               precision,
    input  logic                        relu_en,
    input  logic [N_IN*DATA_W-1:0]      invec_bus,
    output logic [AW-1:0]               wmem_raddr,
    input  logic [N_LANES*DATA_W-1:0]   wmem_rdata,
    bs_mac_if.master                    res,
    output logic                        busy,
    output logic                        layer_done,
    output logic                        err
);
    localparam int unsigned GW = G > 1 ? $clog2(G) : 1;
    localparam int unsigned IW = N_IN > 1 ? $clog2(N_IN) : 1;
    localparam int unsigned LW = N_LANES > 1 ? $clog2(N_LANES) : 1;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COMPUTE = 2'd1;
    localparam logic [1:0] ST_DRAIN   = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [LIW-1:0]    layer_q, layer_d;
    logic [PW-1:0]     p_q, p_d;
    logic              relu_q, relu_d;
    logic [DATA_W-1:0] x_q [N_IN];
    logic [DATA_W-1:0] x_d [N_IN];
    logic [GW-1:0]     group_q, group_d;
    logic [IW-1:0]     i_q, i_d;
    logic [PW-1:0]     b_q, b_d;
    logic [LW-1:0]     lane_q, lane_d;
    logic [ACC_W-1:0]  acc_q [N_LANES];
    logic [ACC_W-1:0]  acc_d [N_LANES];
    logic [AW-1:0]     raddr_q, raddr_d;
    logic              err_q, err_d;

    logic [PW-1:0]     p_eff;
    logic [AW-1:0]     addr_cur;
    logic [DATA_W-1:0] x_sh;
    logic              x_bit;
    logic              is_msb;
    logic [DATA_W-1:0] w_lane [N_LANES];
    logic [ACC_W-1:0]  w_shift [N_LANES];
    logic [ACC_W-1:0]  drain_val;

    // Out-of-range precision (0 or above DATA_W) falls back to full width.
    assign p_eff    = (precision != '0 && 32'(precision) <= DATA_W) ? precision : PW'(DATA_W);
    assign addr_cur = AW'((32'(layer_q) * G + 32'(group_q)) * N_IN + 32'(i_q));
    assign x_sh     = x_q[i_q] >> b_q;
    assign x_bit    = x_sh[0];
    assign is_msb   = (b_q == p_q - PW'(1));

    always_comb begin
        for (int k = 0; k < N_LANES; k++) begin
            w_lane[k]  = wmem_rdata[k*DATA_W +: DATA_W];
            w_shift[k] = {{(ACC_W - DATA_W){w_lane[k][DATA_W-1]}}, w_lane[k]} << b_q;
        end
    end

    always_comb begin
        state_d = state_q;
        layer_d = layer_q;
        p_d     = p_q;
        relu_d  = relu_q;
        group_d = group_q;
        i_d     = i_q;
        b_d     = b_q;
        lane_d  = lane_q;
        raddr_d = raddr_q;
        err_d   = 1'b0;
        for (int n = 0; n < N_IN; n++) x_d[n] = x_q[n];
        for (int k = 0; k < N_LANES; k++) acc_d[k] = acc_q[k];

        case (state_q)
            ST_IDLE: begin
                if (start_compute) begin
                    if (32'(layer_idx) < N_LAYERS) begin
                        state_d = ST_COMPUTE;
                        layer_d = layer_idx;
                        p_d     = p_eff;
                        relu_d  = relu_en;
                        group_d = '0;
                        i_d     = '0;
                        b_d     = '0;
                        lane_d  = '0;
                        for (int n = 0; n < N_IN; n++) x_d[n] = invec_bus[n*DATA_W +: DATA_W];
                        for (int k = 0; k < N_LANES; k++) acc_d[k] = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_COMPUTE: begin
                raddr_d = addr_cur;
                // Sign bit of the p-bit input carries weight -2^(p-1).
                if (x_bit) begin
                    for (int k = 0; k < N_LANES; k++) begin
                        acc_d[k] = is_msb ? acc_q[k] - w_shift[k] : acc_q[k] + w_shift[k];
                    end
                end
                if (is_msb) begin
                    b_d = '0;
                    if (i_q == IW'(N_IN - 1)) begin
                        i_d     = '0;
                        lane_d  = '0;
                        state_d = ST_DRAIN;
                    end else begin
                        i_d = i_q + IW'(1);
                    end
                end else begin
                    b_d = b_q + PW'(1);
                end
            end
            ST_DRAIN: begin
                if (res.out_ready) begin
                    if (lane_q == LW'(N_LANES - 1)) begin
                        lane_d = '0;
                        if (group_q == GW'(G - 1)) begin
                            state_d = ST_DONE;
                        end else begin
                            group_d = group_q + GW'(1);
                            for (int k = 0; k < N_LANES; k++) acc_d[k] = '0;
                            state_d = ST_COMPUTE;
                        end
                    end else begin
                        lane_d = lane_q + LW'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            layer_q <= '0;
            p_q     <= '0;
            relu_q  <= 1'b0;
            group_q <= '0;
            i_q     <= '0;
            b_q     <= '0;
            lane_q  <= '0;
            raddr_q <= '0;
            err_q   <= 1'b0;
            for (int n = 0; n < N_IN; n++) x_q[n] <= '0;
            for (int k = 0; k < N_LANES; k++) acc_q[k] <= '0;
        end else begin
            state_q <= state_d;
            layer_q <= layer_d;
            p_q     <= p_d;
            relu_q  <= relu_d;
            group_q <= group_d;
            i_q     <= i_d;
            b_q     <= b_d;
            lane_q  <= lane_d;
            raddr_q <= raddr_d;
            err_q   <= err_d;
            for (int n = 0; n < N_IN; n++) x_q[n] <= x_d[n];
            for (int k = 0; k < N_LANES; k++) acc_q[k] <= acc_d[k];
        end
    end

    always_comb begin
        drain_val = acc_q[lane_q];
        if (relu_q && drain_val[ACC_W-1]) drain_val = '0;
        res.out_valid = (state_q == ST_DRAIN);
        res.out_data  = (state_q == ST_DRAIN) ? drain_val : '0;
        res.out_idx   = (state_q == ST_DRAIN) ?
                        IDX_W'(32'(group_q) * N_LANES + 32'(lane_q)) : '0;
    end

    // The address register only tracks COMPUTE so the bus holds its last value elsewhere.
    assign wmem_raddr = (state_q == ST_COMPUTE) ? addr_cur : raddr_q;
    assign busy       = (state_q != ST_IDLE);
    assign layer_done = (state_q == ST_DONE);
    assign err        = err_q;
endmodule
